// File: rtl/pipe_stage_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_buf_pkg : shared types and helpers for pipe_stage_buf      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package pipe_stage_buf_pkg;

    // Upper bound on the slot count seen by the kill counter.
    localparam int unsigned MAX_SLOTS = 64;

    typedef struct packed {
        logic load;
        logic clear;
    } slot_ctrl_t;

    function automatic int unsigned count_ones(input logic [MAX_SLOTS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_SLOTS; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_slot : one valid+data register with load / clear / hold          |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pipe_slot
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  slot_ctrl_t       ctrl,
    input  logic [WIDTH-1:0] din,
    output logic             valid,
    output logic [WIDTH-1:0] dout
);

    // Load wins over clear: an item arriving replaces one leaving or killed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (ctrl.load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ctrl.clear) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipe_stage_buf : elastic valid/ready register chain with slot flush   |
// | Optional skid entry ahead of slot 0: define PIPE_STAGE_BUF_SKID_EN    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1,
    parameter int CNT_W  = $clog2(STAGES + 2)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  data_i,
    input  logic [STAGES-1:0] flush_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  data_o,
    output logic [CNT_W-1:0]  occupancy_o
);

    logic [STAGES-1:0] slot_valid;
    logic [STAGES-1:0] eff_flush;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] can_load;
    logic [STAGES-1:0] killed;
    logic [WIDTH-1:0]  slot_data [STAGES];
    logic [WIDTH-1:0]  load_data [STAGES];
    slot_ctrl_t        slot_ctrl [STAGES];
    logic              downstream;
    logic              src_valid;
    logic [WIDTH-1:0]  src_data;
    logic              accept;
    logic              extra_kill;
    logic              out_xfer;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  occ_next;

    // Ready/advance chain, resolved from the output slot back to slot 0.
    // A flush on the output slot is ignored while the transfer completes.
    always_comb begin
        eff_flush           = flush_i;
        eff_flush[STAGES-1] = flush_i[STAGES-1] & ~ready_i;
        adv                 = '0;
        can_load            = '0;
        downstream          = ready_i;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k]      = slot_valid[k] & ~eff_flush[k] & downstream;
            can_load[k] = ~slot_valid[k] | eff_flush[k] | adv[k];
            downstream  = can_load[k];
        end
        killed = slot_valid & eff_flush;
    end

`ifdef PIPE_STAGE_BUF_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;

    assign ready_o    = ~skid_valid;
    assign accept     = valid_i & ~skid_valid;
    assign src_valid  = (skid_valid & ~flush_i[0]) | accept;
    assign src_data   = skid_valid ? skid_data : data_i;
    assign extra_kill = skid_valid & flush_i[0];

    // The skid entry drains into slot 0 ahead of any new input.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (skid_valid) begin
            if (flush_i[0] | can_load[0]) skid_valid <= 1'b0;
        end else if (accept & ~can_load[0]) begin
            skid_valid <= 1'b1;
            skid_data  <= data_i;
        end
    end
`else
    assign ready_o    = can_load[0];
    assign accept     = valid_i & can_load[0];
    assign src_valid  = valid_i;
    assign src_data   = data_i;
    assign extra_kill = 1'b0;
`endif

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            slot_ctrl[k].clear = adv[k] | killed[k];
            slot_ctrl[k].load  = 1'b0;
            load_data[k]       = src_data;
        end
        slot_ctrl[0].load = can_load[0] & src_valid;
        for (int k = 1; k < STAGES; k++) begin
            slot_ctrl[k].load = can_load[k] & adv[k-1];
            load_data[k]      = slot_data[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk_i),
            .rst_n (rst_ni),
            .ctrl  (slot_ctrl[k]),
            .din   (load_data[k]),
            .valid (slot_valid[k]),
            .dout  (slot_data[k])
        );
    end

    assign out_xfer = adv[STAGES-1];

    always_comb begin
        occ_next = occupancy
                 + CNT_W'(accept)
                 - CNT_W'(out_xfer)
                 - CNT_W'(count_ones(MAX_SLOTS'(killed)))
                 - CNT_W'(extra_kill);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occupancy <= '0;
        end else begin
            occupancy <= occ_next;
        end
    end

    assign valid_o     = slot_valid[STAGES-1];
    assign data_o      = slot_data[STAGES-1];
    assign occupancy_o = occupancy;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pipe_stage_buf : directed stimulus with queue-based output checker |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_pipe_stage_buf;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int CNT_W  = 3;
`ifdef PIPE_STAGE_BUF_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              valid_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [WIDTH-1:0]  data_i  = '0;
    logic [STAGES-1:0] flush_i = '0;
    logic              ready_o;
    logic              valid_o;
    logic [WIDTH-1:0]  data_o;
    logic [CNT_W-1:0]  occupancy_o;

    logic [WIDTH-1:0]  exp_q [$];
    logic [WIDTH-1:0]  mon_exp;
    int                tests = 0;
    int                fails = 0;
    bit                last_acc;
    bit                last_rdy;
    bit                pending;
    int                n;

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .flush_i     (flush_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .occupancy_o (occupancy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: every transfer must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && valid_o && ready_i) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL out_unexpected: got 0x%0h, expected no output", data_o);
            end else begin
                mon_exp = exp_q.pop_front();
                if (data_o !== mon_exp) begin
                    fails++;
                    $display("FAIL out_data: got 0x%0h, expected 0x%0h", data_o, mon_exp);
                end
            end
        end
    end

    // One clock cycle of stimulus; inputs change just after the rising edge.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic [STAGES-1:0] f, input bit push);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        flush_i = f;
        @(negedge clk);
        last_acc = v & ready_o;
        last_rdy = ready_o;
        if (last_acc && push) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((occupancy_o != 0) && (k < 20)) begin
            cyc(1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
            k++;
        end
        check({name, "_occ_empty"}, 32'(occupancy_o), 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // 1: reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", 32'(valid_o), 0);
        check("rst_data_o", 32'(data_o), 0);
        check("rst_occ", 32'(occupancy_o), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_ready_o", 32'(ready_o), 1);

        // 2: unstalled stream, latency and steady occupancy
        cyc(1'b1, 8'h11, 1'b1, 3'b000, 1'b1);
        check("t2_acc_first", 32'(last_acc), 1);
        check("t2_lat_e0", 32'(valid_o), 0);
        cyc(1'b1, 8'h22, 1'b1, 3'b000, 1'b1);
        check("t2_lat_e1", 32'(valid_o), 0);
        cyc(1'b1, 8'h33, 1'b1, 3'b000, 1'b1);
        check("t2_lat_e2", 32'(valid_o), 1);
        check("t2_occ_a", 32'(occupancy_o), 3);
        cyc(1'b1, 8'h44, 1'b1, 3'b000, 1'b1);
        check("t2_acc_last", 32'(last_acc), 1);
        check("t2_occ_b", 32'(occupancy_o), 3);
        drain("t2");

        // 3: stalled stream fills, holds, then drains in order
        cyc(1'b1, 8'h11, 1'b0, 3'b000, 1'b1);
        cyc(1'b1, 8'h22, 1'b0, 3'b000, 1'b1);
        cyc(1'b1, 8'h33, 1'b0, 3'b000, 1'b1);
        check("t3_occ_full", 32'(occupancy_o), 3);
        check("t3_ready_full", 32'(ready_o), SKID ? 1 : 0);
        check("t3_data_hold", 32'(data_o), 32'h11);
        pending = 1'b1;
        repeat (2) begin
            if (pending) begin
                cyc(1'b1, 8'h44, 1'b0, 3'b000, 1'b1);
                if (last_acc) pending = 1'b0;
            end else begin
                cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
            end
        end
        check("t3_occ_stall", 32'(occupancy_o), SKID ? 4 : 3);
        check("t3_data_stall", 32'(data_o), 32'h11);
        n = 0;
        while (pending && (n < 5)) begin
            cyc(1'b1, 8'h44, 1'b1, 3'b000, 1'b1);
            if (last_acc) pending = 1'b0;
            n++;
        end
        check("t3_acc_44", 32'(pending), 0);
        drain("t3");

        // 4: flush the two youngest items of a full, stalled chain
        cyc(1'b1, 8'h11, 1'b0, 3'b000, 1'b0);
        exp_q.push_back(8'h11);
        cyc(1'b1, 8'h22, 1'b0, 3'b000, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, 3'b000, 1'b0);
        check("t4_occ_full", 32'(occupancy_o), 3);
        cyc(1'b0, 8'h00, 1'b0, 3'b011, 1'b0);
        check("t4_ready_flush", 32'(last_rdy), 1);
        check("t4_occ_flush", 32'(occupancy_o), 1);
        check("t4_head_valid", 32'(valid_o), 1);
        check("t4_head_data", 32'(data_o), 32'h11);
        drain("t4");

        // 4b: flush on the output slot during a transfer has no effect
        cyc(1'b1, 8'h5A, 1'b0, 3'b000, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
        check("t4b_at_output", 32'(valid_o), 1);
        cyc(1'b0, 8'h00, 1'b1, 3'b100, 1'b0);
        check("t4b_occ", 32'(occupancy_o), 0);
        check("t4b_queue", exp_q.size(), 0);

        // 5: bubbles compact toward the output while stalled
        cyc(1'b1, 8'hA1, 1'b0, 3'b000, 1'b1);
        check("t5_acc_a1", 32'(last_acc), 1);
        cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
        cyc(1'b1, 8'hA2, 1'b0, 3'b000, 1'b1);
        check("t5_acc_a2", 32'(last_acc), 1);
        cyc(1'b0, 8'h00, 1'b0, 3'b000, 1'b0);
        check("t5_occ", 32'(occupancy_o), 2);
        check("t5_head", 32'(data_o), 32'hA1);
        cyc(1'b0, 8'h00, 1'b1, 3'b000, 1'b0);
        check("t5_b2b_valid", 32'(valid_o), 1);
        check("t5_b2b_data", 32'(data_o), 32'hA2);
        drain("t5");

`ifdef PIPE_STAGE_BUF_SKID_EN
        // 6: skid entry extends capacity and ready_o is registered
        cyc(1'b1, 8'h11, 1'b0, 3'b000, 1'b1);
        cyc(1'b1, 8'h22, 1'b0, 3'b000, 1'b1);
        cyc(1'b1, 8'h33, 1'b0, 3'b000, 1'b1);
        cyc(1'b1, 8'h44, 1'b0, 3'b000, 1'b1);
        check("t6_acc_skid", 32'(last_acc), 1);
        check("t6_occ", 32'(occupancy_o), 4);
        check("t6_ready_full", 32'(ready_o), 0);
        cyc(1'b1, 8'h55, 1'b0, 3'b000, 1'b1);
        check("t6_no_acc", 32'(last_acc), 0);
        valid_i = 1'b0;
        ready_i = 1'b1;
        #1;
        check("t6_ready_no_comb", 32'(ready_o), 0);
        ready_i = 1'b0;
        @(posedge clk);
        #1;
        drain("t6");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
